dft_single_bin_e: RTL and testbench
===================================

Name: dft_single_bin_e

Overview:
- Computes one DFT bin X[k] = Σ x[n]·e^(−j2πkn/N) incrementally, one sample at a time.
- Each write-strobed sample x[n] runs through a multi-cycle pipeline:
  - index = (k·n) mod N
  - twiddle phase lookup
  - complex multiply-accumulate into the bin.
- Used as a per-bin worker in the DFT datapath; results are read from o_X once o_done is high.

Parameters:
- WIDTH, 8: width of sample, k, n, N, twiddle components and accumulator outputs.
- PHASE_BITS, 8: phase resolution, 2^PHASE_BITS steps per turn. Must be even and ≥4.

Ports:
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_x  in  WIDTH signed  input sample x[n].
- i_wr  in  1  sample-write strobe; sampled only in IDLE or DONE.
- i_k  in  WIDTH unsigned  bin number k.
- i_n  in  WIDTH unsigned  sample index n; any value, wrapped mod N.
- i_N  in  WIDTH unsigned  transform length N.
- o_X  out  2×WIDTH signed  unpacked array: [0] = real, [1] = imaginary accumulated bin.
- o_done  out  1  sample processed, result valid.
- c  out  2×WIDTH signed  current twiddle: [0] = cos θ, [1] = −sin θ, in Q2.(WIDTH−2).
- Vectors are declared big-endian, [0:WIDTH−1].

Behaviour:
- Reset is synchronous, active-high. On reset:
  - o_X = 0, c = 0, o_done = 0
  - state = IDLE, internal registers cleared.
- Reset mid-operation aborts the sample; the accumulator is cleared.
- Fixed point: ONE = 2^(WIDTH−2), so 1.0 = 64 when WIDTH = 8.
- States (3-bit encoding): IDLE → MOD → PHASE → LUT → MAC → DONE.
- IDLE/DONE, i_wr = 1:
  - Register x, k, N.
  - Register p = k·n (2·WIDTH bits).
  - Clear o_done; go to MOD.
- MOD:
  - Radix-4 restoring division, 2 quotient bits per cycle.
  - WIDTH cycles yield idx = p mod N (remainder only).
- PHASE:
  - Same divider computes ph = floor(idx·2^PHASE_BITS / N).
  - PHASE_BITS/2 cycles.
  - θ = 2π·ph/2^PHASE_BITS.
- LUT:
  - Quarter-wave table lookup with quadrant symmetry.
  - Registers c[0] = round(ONE·cos θ) and c[1] = −round(ONE·sin θ).
- MAC:
  - X[0] += (x·c[0]) >>> (WIDTH−2); X[1] += (x·c[1]) >>> (WIDTH−2).
  - Products are full 2·WIDTH bits, shifted arithmetically, truncated to WIDTH.
  - Accumulation wraps in two's complement.
- DONE:
  - o_done = 1, held until the next accepted i_wr.
  - o_X and c are stable.
- Latency:
  - o_done rises 1 + WIDTH + PHASE_BITS/2 + 2 cycles after the i_wr edge (15 for defaults).
  - Next-sample spacing ≥ 16 cycles is always safe.
- Boundary conditions:
  - i_wr in MOD/PHASE/LUT/MAC is ignored; no queueing.
  - i_wr held high in DONE starts exactly one new sample per acceptance edge.
  - N = 0: idx = 0, c = (ONE, 0); no divide attempted.
  - n ≥ N and k ≥ N are legal and reduced mod N.
- The accumulator is cleared only by reset.

Optional Feature:
- Macro: DFT_SINGLEBIN_DEBUG_EN.
- When defined, adds two outputs:
  - state (3 bits): current FSM encoding, IDLE = 0 … DONE = 5.
  - index (WIDTH bits): registered idx.
- When undefined, these ports and their registers do not exist.
- Function and timing are identical either way.

Decomposition:
- Shared package dft_pkg holds:
  - state enum typedef (3-bit)
  - ONE constant, PHASE_BITS default
  - quarter-wave sine table generator function, evaluated at elaboration.
- One natural sub-module, dft_twiddle_lut:
  - Input ph, registered outputs cos/−sin.
  - Handles quadrant folding.
- The divider stays inline in the FSM.

Test Plan:
- k=0, N=2; samples x=0,1,0,1 with n=0..3, one i_wr each, 17 cycles apart:
  - c = (64, 0) each time.
  - Final o_X = (2, 0); o_done high 15 cycles after each i_wr.
- k=1, N=2:
  - x=1, n=0 → c = (64, 0), X = (1, 0).
  - Then x=1, n=1 → c = (−64, 0), X = (0, 0).
- k=1, N=4, x=1, n=1 → c = (0, −64), X = (0, −1). Then n=2, x=2 → c = (−64, 0), X = (−2, −1).
- i_wr pulsed again 3 cycles after an accepted i_wr → ignored:
  - Only one MAC occurs.
  - o_done timing unchanged.
- Reset asserted during PHASE:
  - Next cycle o_X = 0, c = 0, o_done = 0, state IDLE.
  - A subsequent sample is processed normally.
- N=0, k=3, n=5, x=−3 → c = (64, 0), X = (−3, 0).

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types and constants for the single-bin DFT worker: FSM encoding,
// default widths, and the elaboration-time quarter-wave sine generator.
package dft_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOD   = 3'd1,
    S_PHASE = 3'd2,
    S_LUT   = 3'd3,
    S_MAC   = 3'd4,
    S_DONE  = 3'd5
  } dft_state_e;

  localparam int DFT_WIDTH      = 8;
  localparam int DFT_PHASE_BITS = 8;
  localparam int DFT_ONE        = 1 << (DFT_WIDTH - 2);

  // round(one * sin(pi/2 * i/q)) using a Q30 Taylor series, so no real math is needed
  function automatic int qsin(input int i, input int q, input int one);
    longint x, x2, t, s;
    x  = (64'sd3373259426 * longint'(i)) / longint'(2 * q);
    x2 = (x * x) >>> 30;
    t  = x;
    s  = x;
    for (int m = 1; m <= 7; m++) begin
      t = -((t * x2) >>> 30) / longint'((2 * m) * (2 * m + 1));
      s = s + t;
    end
    return int'((longint'(one) * s + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dft_twiddle_lut.sv
// Twiddle lookup: quarter-wave sine table folded over four quadrants,
// registering cos(theta) and -sin(theta) when load is high.
module dft_twiddle_lut
  import dft_pkg::*;
#(
  parameter int WIDTH      = DFT_WIDTH,
  parameter int PHASE_BITS = DFT_PHASE_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [PHASE_BITS-1:0]   ph,
  output logic signed [WIDTH-1:0] cos_val,
  output logic signed [WIDTH-1:0] nsin_val
);

  localparam int Q   = 1 << (PHASE_BITS - 2);
  localparam int ONE = 1 << (WIDTH - 2);

  logic signed [WIDTH-1:0] tab [0:Q];

  for (genvar i = 0; i <= Q; i++) begin : g_tab
    localparam int V = qsin(i, Q, ONE);
    assign tab[i] = WIDTH'(V);
  end

  logic [1:0]              quad;
  logic [PHASE_BITS-2:0]   off, offc;
  logic signed [WIDTH-1:0] sa, sb, cos_n, sin_n;

  always_comb begin
    quad = ph[PHASE_BITS-1 -: 2];
    off  = {1'b0, ph[PHASE_BITS-3:0]};
    offc = (PHASE_BITS - 1)'(Q) - off;
    sa   = tab[off];
    sb   = tab[offc];
    case (quad)
      2'd0:    begin cos_n = sb;  sin_n = sa;  end
      2'd1:    begin cos_n = -sa; sin_n = sb;  end
      2'd2:    begin cos_n = -sb; sin_n = -sa; end
      default: begin cos_n = sa;  sin_n = -sb; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cos_val  <= '0;
      nsin_val <= '0;
    end else if (load) begin
      cos_val  <= cos_n;
      nsin_val <= -sin_n;
    end
  end

endmodule

// File: rtl/dft_single_bin_e.sv
// Single DFT bin worker: per sample computes (k*n) mod N, the phase, the twiddle,
// then MACs into X. Define DFT_SINGLEBIN_DEBUG_EN to expose state and index ports.
module dft_single_bin_e
  import dft_pkg::*;
#(
  parameter int WIDTH      = DFT_WIDTH,
  parameter int PHASE_BITS = DFT_PHASE_BITS
) (
  input  logic                    i_sys_clk,
  input  logic                    i_reset,
  input  logic signed [0:WIDTH-1] i_x,
  input  logic                    i_wr,
  input  logic [0:WIDTH-1]        i_k,
  input  logic [0:WIDTH-1]        i_n,
  input  logic [0:WIDTH-1]        i_N,
  output logic signed [0:WIDTH-1] o_X [0:1],
  output logic                    o_done,
  output logic signed [0:WIDTH-1] c [0:1]
`ifdef DFT_SINGLEBIN_DEBUG_EN
  ,
  output logic [2:0]              state,
  output logic [0:WIDTH-1]        index
`endif
);

  localparam int WW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + PHASE_BITS) + 1;

  dft_state_e st, st_nx;

  logic signed [WIDTH-1:0] x_r, acc_re, acc_im, c_re, c_im;
  logic [WIDTH-1:0]        nr, rem;
  logic [WW-1:0]           pr;
  logic [PHASE_BITS-1:0]   ph_r;
  logic [CW-1:0]           cnt;
  logic                    done, accept, nz, last_mod, last_ph;

  assign accept   = ((st == S_IDLE) || (st == S_DONE)) && i_wr;
  assign nz       = (nr != '0);
  assign last_mod = (cnt == CW'(WIDTH - 1));
  assign last_ph  = (cnt == CW'(PHASE_BITS / 2 - 1));

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) st <= S_IDLE;
    else         st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE, S_DONE: if (accept) st_nx = S_MOD;
      S_MOD:          if (last_mod) st_nx = S_PHASE;
      S_PHASE:        if (last_ph) st_nx = S_LUT;
      S_LUT:          st_nx = S_MAC;
      S_MAC:          st_nx = S_DONE;
      default:        st_nx = S_IDLE;
    endcase
  end

  // Radix-4 restoring step; PHASE feeds zeros so the quotient becomes idx*2^PHASE_BITS/N
  logic [1:0]       din, qd;
  logic [WIDTH+1:0] r4, n1, n2, n3;
  logic [WIDTH-1:0] rsub;

  always_comb begin
    din  = (st == S_MOD) ? pr[WW-1 -: 2] : 2'b00;
    r4   = {rem, din};
    n1   = {2'b00, nr};
    n2   = {1'b0, nr, 1'b0};
    n3   = n1 + n2;
    qd   = 2'd0;
    rsub = WIDTH'(r4);
    if (r4 >= n3) begin
      qd   = 2'd3;
      rsub = WIDTH'(r4 - n3);
    end else if (r4 >= n2) begin
      qd   = 2'd2;
      rsub = WIDTH'(r4 - n2);
    end else if (r4 >= n1) begin
      qd   = 2'd1;
      rsub = WIDTH'(r4 - n1);
    end
  end

  logic signed [WW-1:0] pre, pim;
  assign pre = (WW'(x_r) * WW'(c_re)) >>> (WIDTH - 2);
  assign pim = (WW'(x_r) * WW'(c_im)) >>> (WIDTH - 2);

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      x_r    <= '0;
      nr     <= '0;
      pr     <= '0;
      rem    <= '0;
      ph_r   <= '0;
      cnt    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      done   <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (accept) begin
            x_r  <= i_x;
            nr   <= i_N;
            pr   <= {{WIDTH{1'b0}}, i_k} * {{WIDTH{1'b0}}, i_n};
            rem  <= '0;
            ph_r <= '0;
            cnt  <= '0;
            done <= 1'b0;
          end else if (st == S_DONE) begin
            done <= 1'b1;
          end
        end
        S_MOD: begin
          if (nz) rem <= rsub;
          pr  <= pr << 2;
          cnt <= last_mod ? '0 : cnt + 1'b1;
        end
        S_PHASE: begin
          if (nz) begin
            rem  <= rsub;
            ph_r <= {ph_r[PHASE_BITS-3:0], qd};
          end
          cnt <= cnt + 1'b1;
        end
        S_MAC: begin
          acc_re <= acc_re + pre[WIDTH-1:0];
          acc_im <= acc_im + pim[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  dft_twiddle_lut #(
    .WIDTH      (WIDTH),
    .PHASE_BITS (PHASE_BITS)
  ) u_lut (
    .clk      (i_sys_clk),
    .rst      (i_reset),
    .load     (st == S_LUT),
    .ph       (ph_r),
    .cos_val  (c_re),
    .nsin_val (c_im)
  );

  assign o_X[0] = acc_re;
  assign o_X[1] = acc_im;
  assign c[0]   = c_re;
  assign c[1]   = c_im;
  assign o_done = done;

`ifdef DFT_SINGLEBIN_DEBUG_EN
  logic [WIDTH-1:0] idx_r;
  always_ff @(posedge i_sys_clk) begin
    if (i_reset)                     idx_r <= '0;
    else if (st == S_MOD && last_mod) idx_r <= nz ? rsub : '0;
  end
  assign state = st;
  assign index = idx_r;
`endif

endmodule

// File: tb/tb_dft_single_bin_e.sv
// Bench for dft_single_bin_e: directed cases plus random samples against a
// trigonometric reference model of one DFT bin.
module tb_dft_single_bin_e;
  import dft_pkg::*;

  localparam int  W   = DFT_WIDTH;
  localparam int  PB  = DFT_PHASE_BITS;
  localparam int  ONE = DFT_ONE;
  localparam real PI  = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [0:W-1] i_x;
  logic                i_wr;
  logic [0:W-1]        i_k, i_n, i_N;
  logic signed [0:W-1] o_X [0:1];
  logic                o_done;
  logic signed [0:W-1] c [0:1];
`ifdef DFT_SINGLEBIN_DEBUG_EN
  logic [2:0]          dbg_state;
  logic [0:W-1]        dbg_index;
`endif

  dft_single_bin_e #(.WIDTH(W), .PHASE_BITS(PB)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .i_x       (i_x),
    .i_wr      (i_wr),
    .i_k       (i_k),
    .i_n       (i_n),
    .i_N       (i_N),
    .o_X       (o_X),
    .o_done    (o_done),
    .c         (c)
`ifdef DFT_SINGLEBIN_DEBUG_EN
    ,
    .state     (dbg_state),
    .index     (dbg_index)
`endif
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;
  int m_re   = 0;
  int m_im   = 0;
  int m_c0   = 0;
  int m_c1   = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    ntotal++;
    assert (obs === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi($floor(r + 0.5)) : -$rtoi($floor(-r + 0.5));
  endfunction

  function automatic int wrapw(input int v);
    int m;
    m = ((v % (1 << W)) + (1 << W)) % (1 << W);
    return (m >= (1 << (W - 1))) ? m - (1 << W) : m;
  endfunction

  // floor(p / 2^(W-2)), i.e. an arithmetic right shift
  function automatic int fshift(input int p);
    int d;
    d = 1 << (W - 2);
    return (p - (((p % d) + d) % d)) / d;
  endfunction

  task automatic model(input int x, input int k, input int n, input int nn);
    int  idx, ph;
    real th;
    if (nn == 0) begin
      m_c0 = ONE;
      m_c1 = 0;
    end else begin
      idx  = (k * n) % nn;
      ph   = (idx * (1 << PB)) / nn;
      th   = 2.0 * PI * ph / (1 << PB);
      m_c0 = rnd(ONE * $cos(th));
      m_c1 = -rnd(ONE * $sin(th));
    end
    m_re = wrapw(m_re + fshift(x * m_c0));
    m_im = wrapw(m_im + fshift(x * m_c1));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_re = 0;
    m_im = 0;
  endtask

  task automatic start(input int x, input int k, input int n, input int nn);
    i_x  = W'(x);
    i_k  = W'(k);
    i_n  = W'(n);
    i_N  = W'(nn);
    i_wr = 1'b1;
    tick(1);
    i_wr = 1'b0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "/c0"}, 32'(c[0]), m_c0);
    chk({tag, "/c1"}, 32'(c[1]), m_c1);
    chk({tag, "/Xre"}, 32'(o_X[0]), m_re);
    chk({tag, "/Xim"}, 32'(o_X[1]), m_im);
  endtask

  task automatic sample(input string tag, input int x, input int k, input int n, input int nn);
    start(x, k, n, nn);
    tick(14);
    chk({tag, "/done_lo"}, 32'(o_done), 0);
    tick(1);
    chk({tag, "/done_hi"}, 32'(o_done), 1);
    model(x, k, n, nn);
    chk_out(tag);
  endtask

  initial begin
    int x, k, n, nn;
    rst  = 1'b1;
    i_wr = 1'b0;
    i_x  = '0;
    i_k  = '0;
    i_n  = '0;
    i_N  = '0;
    tick(2);
    chk("rst/Xre", 32'(o_X[0]), 0);
    chk("rst/Xim", 32'(o_X[1]), 0);
    chk("rst/c0", 32'(c[0]), 0);
    chk("rst/c1", 32'(c[1]), 0);
    chk("rst/done", 32'(o_done), 0);
    rst = 1'b0;
    tick(1);

    // k=0, N=2: twiddle is always 1, so X sums the samples
    for (int i = 0; i < 4; i++) begin
      sample("k0n2", i % 2, 0, i, 2);
      chk("k0n2/c0_lit", 32'(c[0]), 64);
      tick(1);
    end
    chk("k0n2/final_re", 32'(o_X[0]), 2);
    chk("k0n2/final_im", 32'(o_X[1]), 0);

    do_reset();
    sample("k1n2_a", 1, 1, 0, 2);
    chk("k1n2_a/Xre_lit", 32'(o_X[0]), 1);
    sample("k1n2_b", 1, 1, 1, 2);
    chk("k1n2_b/c0_lit", 32'(c[0]), -64);
    chk("k1n2_b/Xre_lit", 32'(o_X[0]), 0);

    do_reset();
    sample("k1n4_a", 1, 1, 1, 4);
    chk("k1n4_a/c1_lit", 32'(c[1]), -64);
    chk("k1n4_a/Xim_lit", 32'(o_X[1]), -1);
    sample("k1n4_b", 2, 1, 2, 4);
    chk("k1n4_b/Xre_lit", 32'(o_X[0]), -2);
    chk("k1n4_b/Xim_lit", 32'(o_X[1]), -1);

    // second strobe three cycles into processing must be dropped
    do_reset();
    start(5, 1, 1, 8);
    tick(2);
    i_x  = W'(100);
    i_wr = 1'b1;
    tick(1);
    i_wr = 1'b0;
    tick(11);
    chk("ign/done_lo", 32'(o_done), 0);
    tick(1);
    chk("ign/done_hi", 32'(o_done), 1);
    model(5, 1, 1, 8);
    chk_out("ign");
    tick(20);
    chk("ign/late_Xre", 32'(o_X[0]), m_re);
    chk("ign/late_done", 32'(o_done), 1);

    // reset while in PHASE aborts the sample and clears everything
    start(5, 3, 7, 11);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_re = 0;
    m_im = 0;
    chk("midrst/Xre", 32'(o_X[0]), 0);
    chk("midrst/Xim", 32'(o_X[1]), 0);
    chk("midrst/c0", 32'(c[0]), 0);
    chk("midrst/c1", 32'(c[1]), 0);
    chk("midrst/done", 32'(o_done), 0);
`ifdef DFT_SINGLEBIN_DEBUG_EN
    chk("midrst/state", 32'(dbg_state), 0);
`endif
    sample("after_rst", 7, 3, 7, 11);

    do_reset();
    sample("n0", -3, 3, 5, 0);
    chk("n0/c0_lit", 32'(c[0]), 64);
    chk("n0/Xre_lit", 32'(o_X[0]), -3);

    // strobe held high: one new sample per acceptance in DONE
    do_reset();
    i_x  = W'(-7);
    i_k  = W'(5);
    i_n  = W'(9);
    i_N  = W'(13);
    i_wr = 1'b1;
    tick(15);
    chk("hold/done_lo1", 32'(o_done), 0);
    model(-7, 5, 9, 13);
    chk_out("hold1");
    tick(1);
    i_wr = 1'b0;
    chk("hold/done_lo2", 32'(o_done), 0);
    tick(14);
    chk("hold/done_lo3", 32'(o_done), 0);
    tick(1);
    chk("hold/done_hi", 32'(o_done), 1);
    model(-7, 5, 9, 13);
    chk_out("hold2");

    do_reset();
    for (int i = 0; i < 24; i++) begin
      x  = int'($urandom_range(0, 255)) - 128;
      k  = int'($urandom_range(0, 255));
      n  = int'($urandom_range(0, 255));
      if (i % 6 == 5)      nn = 0;
      else if (i % 2 == 0) nn = int'($urandom_range(1, 16));
      else                 nn = int'($urandom_range(1, 255));
      sample("rand", x, k, n, nn);
      tick(int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
